// File: rtl/csr_irq_ctrl_if.sv
// Core-side bundle for csr_irq_ctrl: interrupt lines, EX-stage CSR/mret
// request and the PC redirect / CSR read-data results.
interface csr_irq_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic               inst_valid;
  logic [31:0]        pc;
  logic               csr_rd;
  logic               csr_wr;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic               is_mret;
  logic [31:0]        csr_rdata;
  logic               trap_taken;
  logic [31:0]        redirect_pc;

  modport master (
    output irq, inst_valid, pc, csr_rd, csr_wr, csr_addr, csr_wdata, is_mret,
    input  csr_rdata, trap_taken, redirect_pc
  );

  modport slave (
    input  irq, inst_valid, pc, csr_rd, csr_wr, csr_addr, csr_wdata, is_mret,
    output csr_rdata, trap_taken, redirect_pc
  );
endinterface

// File: rtl/csr_irq_ctrl.sv
// Machine-mode CSR file and fixed-priority interrupt controller with a RUN/REDIRECT FSM.
// Define CSR_IRQ_SYNC_EN to pass each irq line through a 2-flop synchroniser.
module csr_irq_ctrl #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input logic           clk,
  input logic           rst,
  csr_irq_ctrl_if.slave bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  typedef enum logic {
    ST_RUN,
    ST_REDIRECT
  } state_t;

  state_t             state_q, state_d;
  logic               mie_bit_q, mie_bit_d;
  logic               mpie_q, mpie_d;
  logic [NUM_IRQ-1:0] mie_q, mie_d;
  logic [31:0]        mepc_q, mepc_d;
  logic [31:0]        mcause_q, mcause_d;
  logic [31:0]        mtvec_q, mtvec_d;
  logic [31:0]        tgt_q, tgt_d;

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] pend;
  logic               in_run;
  logic               take;
  logic               csr_commit;
  logic               mret_fire;
  logic [31:0]        cause;
  logic [31:0]        tvec_base;
  logic [31:0]        handler;
  logic [31:0]        mstatus_val;
  logic [31:0]        mie_val;
  logic [31:0]        mip_val;
  logic [31:0]        rdata_c;

`ifdef CSR_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.irq;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = bus.irq;
`endif

  assign pend       = irq_s & mie_q;
  assign in_run     = (state_q == ST_RUN);
  assign take       = in_run && bus.inst_valid && mie_bit_q && (|pend);
  // A taken trap squashes the EX instruction, so its CSR write or mret must not land.
  assign csr_commit = in_run && bus.inst_valid && bus.csr_wr && !take;
  assign mret_fire  = in_run && bus.inst_valid && bus.is_mret && !take;

  // Scan from the top down so the lowest pending index is the one left standing.
  always_comb begin
    cause = 32'd0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (pend[k]) begin
        cause = 32'(16 + k);
      end
    end
  end

  assign tvec_base = {mtvec_q[31:2], 2'b00};
  assign handler   = mtvec_q[0] ? (tvec_base + (cause << 2)) : tvec_base;

  always_comb begin
    mstatus_val    = 32'd0;
    mstatus_val[3] = mie_bit_q;
    mstatus_val[7] = mpie_q;
    mie_val        = 32'd0;
    mie_val[16 +: NUM_IRQ] = mie_q;
    mip_val        = 32'd0;
    mip_val[16 +: NUM_IRQ] = irq_s;
  end

  always_comb begin
    rdata_c = 32'd0;
    if (bus.csr_rd) begin
      case (bus.csr_addr)
        ADDR_MSTATUS: rdata_c = mstatus_val;
        ADDR_MIE:     rdata_c = mie_val;
        ADDR_MTVEC:   rdata_c = mtvec_q;
        ADDR_MEPC:    rdata_c = mepc_q;
        ADDR_MCAUSE:  rdata_c = mcause_q;
        ADDR_MIP:     rdata_c = mip_val;
        default:      rdata_c = 32'd0;
      endcase
    end
  end

  assign bus.csr_rdata   = rdata_c;
  assign bus.trap_taken  = (state_q == ST_REDIRECT);
  assign bus.redirect_pc = (state_q == ST_REDIRECT) ? tgt_q : 32'd0;

  always_comb begin
    state_d   = state_q;
    mie_bit_d = mie_bit_q;
    mpie_d    = mpie_q;
    mie_d     = mie_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    mtvec_d   = mtvec_q;
    tgt_d     = tgt_q;

    case (state_q)
      ST_RUN: begin
        if (take) begin
          mepc_d    = bus.pc;
          mcause_d  = {1'b1, cause[30:0]};
          mpie_d    = mie_bit_q;
          mie_bit_d = 1'b0;
          tgt_d     = handler;
          state_d   = ST_REDIRECT;
        end else begin
          if (csr_commit) begin
            case (bus.csr_addr)
              ADDR_MSTATUS: begin
                mie_bit_d = bus.csr_wdata[3];
                mpie_d    = bus.csr_wdata[7];
              end
              ADDR_MIE:    mie_d    = bus.csr_wdata[16 +: NUM_IRQ];
              ADDR_MTVEC:  mtvec_d  = bus.csr_wdata & ~32'h0000_0002;
              ADDR_MEPC:   mepc_d   = bus.csr_wdata & ~32'h0000_0003;
              ADDR_MCAUSE: mcause_d = bus.csr_wdata;
              default: ;
            endcase
          end
          // mret uses the pre-write mepc/MPIE and overrides a same-cycle mstatus write.
          if (mret_fire) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
            tgt_d     = mepc_q;
            state_d   = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      mie_bit_q <= 1'b0;
      mpie_q    <= 1'b0;
      mie_q     <= '0;
      mepc_q    <= 32'd0;
      mcause_q  <= 32'd0;
      mtvec_q   <= MTVEC_RESET;
      tgt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      mie_bit_q <= mie_bit_d;
      mpie_q    <= mpie_d;
      mie_q     <= mie_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
      mtvec_q   <= mtvec_d;
      tgt_q     <= tgt_d;
    end
  end

endmodule

// File: tb/tb_csr_irq_ctrl.sv
// Self-checking bench for csr_irq_ctrl: CSR table vectors, hand-written trap/mret
// sequences, and randomized traffic against an event-level reference model.
module tb_csr_irq_ctrl;
  localparam int N = 4;

`ifdef CSR_IRQ_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csr_irq_ctrl_if #(.NUM_IRQ(N)) bus ();

  csr_irq_ctrl #(
    .NUM_IRQ    (N),
    .MTVEC_RESET(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit         m_gie, m_mpie, m_redir;
  bit [N-1:0] m_ien, m_s1, m_s2;
  bit [31:0]  m_mepc, m_mcause, m_mtvec, m_tgt;

  logic [31:0] obs_rdata;
  logic [N-1:0] g_irq = '0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[10];

  logic [11:0] addr_pool[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_gie = 0; m_mpie = 0; m_redir = 0;
    m_ien = '0; m_s1 = '0; m_s2 = '0;
    m_mepc = 0; m_mcause = 0; m_mtvec = 32'h100; m_tgt = 0;
  endfunction

  function automatic bit [31:0] m_read(input bit [11:0] a, input bit [N-1:0] irq_s);
    case (a)
      12'h300: return (m_mpie ? 32'h80 : 32'h0) | (m_gie ? 32'h8 : 32'h0);
      12'h304: return 32'(m_ien) << 16;
      12'h344: return 32'(irq_s) << 16;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(input bit [11:0] a, input bit [31:0] wd);
    case (a)
      12'h300: begin m_gie = wd[3]; m_mpie = wd[7]; end
      12'h304: m_ien = wd[16 +: N];
      12'h305: m_mtvec = wd & ~32'h2;
      12'h341: m_mepc = wd & ~32'h3;
      12'h342: m_mcause = wd;
      default: ;
    endcase
  endfunction

  // One clock of architectural behaviour: trap beats mret and CSR writes.
  function automatic void m_clock(input bit [N-1:0] irq_s, input bit iv, input bit [31:0] pc_v,
                                  input bit wr, input bit [11:0] a, input bit [31:0] wd,
                                  input bit mret);
    bit [N-1:0] pend;
    int         win;
    bit         old_mpie;
    bit [31:0]  old_mepc, base;
    if (m_redir) begin
      m_redir = 0;
      return;
    end
    pend = irq_s & m_ien;
    if (iv && m_gie && pend != 0) begin
      win = 0;
      while (!pend[win]) win++;
      m_mepc   = pc_v;
      m_mcause = 32'h8000_0000 | 32'(16 + win);
      m_mpie   = m_gie;
      m_gie    = 0;
      base     = m_mtvec & ~32'h3;
      m_tgt    = m_mtvec[0] ? base + 32'(4 * (16 + win)) : base;
      m_redir  = 1;
    end else if (iv) begin
      old_mpie = m_mpie;
      old_mepc = m_mepc;
      if (wr) m_write(a, wd);
      if (mret) begin
        m_gie   = old_mpie;
        m_mpie  = 1;
        m_tgt   = old_mepc;
        m_redir = 1;
      end
    end
  endfunction

  // Called at a negedge; drives one cycle, checks rdata before the edge and
  // trap outputs after it.
  task automatic step(input logic [N-1:0] irq_v, input logic iv, input logic [31:0] pc_v,
                      input logic rd, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic mret);
    bit [N-1:0] irq_s;
    bus.irq = irq_v; bus.inst_valid = iv; bus.pc = pc_v; bus.csr_rd = rd;
    bus.csr_wr = wr; bus.csr_addr = a; bus.csr_wdata = wd; bus.is_mret = mret;
    #1;
    irq_s = SYNC ? m_s2 : irq_v;
    obs_rdata = bus.csr_rdata;
    chk("csr_rdata", obs_rdata, rd ? m_read(a, irq_s) : 32'h0);
    m_clock(irq_s, iv, pc_v, wr, a, wd, mret);
    m_s2 = m_s1;
    m_s1 = irq_v;
    @(posedge clk);
    @(negedge clk);
    chk("trap_taken", 32'(bus.trap_taken), 32'(m_redir));
    chk("redirect_pc", bus.redirect_pc, m_redir ? m_tgt : 32'h0);
  endtask

  task automatic hold_irq(input logic [N-1:0] v);
    g_irq = v;
    repeat (2) step(v, 1'b0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(g_irq, 1'b1, 32'h1000, 1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    step(g_irq, 1'b0, 32'h0, 1'b1, 1'b0, a, 32'h0, 1'b0);
    chk(name, obs_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    tbl[0] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
    tbl[1] = '{12'h304, 32'hFFFF_FFFF, 32'h000F_0000};
    tbl[2] = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{12'h341, 32'h0000_0123, 32'h0000_0120};
    tbl[4] = '{12'h342, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tbl[5] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[6] = '{12'h340, 32'h1234_5678, 32'h0000_0000};
    tbl[7] = '{12'hFFF, 32'h0000_0001, 32'h0000_0000};
    tbl[8] = '{12'h305, 32'h0000_0301, 32'h0000_0301};
    tbl[9] = '{12'h304, 32'h000C_0000, 32'h000C_0000};
    addr_pool = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h340, 12'h7C0};

    bus.irq = '0; bus.inst_valid = 0; bus.pc = 0; bus.csr_rd = 0;
    bus.csr_wr = 0; bus.csr_addr = 0; bus.csr_wdata = 0; bus.is_mret = 0;
    m_reset();

    // Reset state
    #1;
    chk("rst_trap_taken", 32'(bus.trap_taken), 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst_csr_rdata", bus.csr_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("rst_mtvec", 12'h305, 32'h0000_0100);

    // Direct trap
    wr(12'h304, 32'h0001_0000);
    wr(12'h305, 32'h0000_0200);
    wr(12'h300, 32'h0000_0008);
    hold_irq(4'b0001);
    step(4'b0001, 1'b1, 32'h40, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    chk("direct_trap_taken", 32'(bus.trap_taken), 32'h1);
    chk("direct_redirect_pc", bus.redirect_pc, 32'h200);
    hold_irq(4'b0000);
    chk("pulse_one_cycle", 32'(bus.trap_taken), 32'h0);
    rd_chk("direct_mepc", 12'h341, 32'h40);
    rd_chk("direct_mcause", 12'h342, 32'h8000_0010);
    rd_chk("direct_mstatus", 12'h300, 32'h80);

    // mret, then level-held irq retraps
    step(4'b0000, 1'b1, 32'h44, 1'b0, 1'b0, 12'h0, 32'h0, 1'b1);
    chk("mret_trap_taken", 32'(bus.trap_taken), 32'h1);
    chk("mret_redirect_pc", bus.redirect_pc, 32'h40);
    rd_chk("mret_mstatus", 12'h300, 32'h88);
    hold_irq(4'b0001);
    step(4'b0001, 1'b1, 32'h40, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    chk("retrap_taken", 32'(bus.trap_taken), 32'h1);
    chk("retrap_pc", bus.redirect_pc, 32'h200);

    // Reset asserted while REDIRECT is active
    rst = 1'b1;
    #1;
    chk("midrst_trap_taken", 32'(bus.trap_taken), 32'h0);
    chk("midrst_redirect_pc", bus.redirect_pc, 32'h0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    g_irq = '0;
    rd_chk("midrst_mtvec", 12'h305, 32'h100);
    rd_chk("midrst_mstatus", 12'h300, 32'h0);
    rd_chk("midrst_mie", 12'h304, 32'h0);
    rd_chk("midrst_mepc", 12'h341, 32'h0);

    // CSR write/readback table
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd_chk($sformatf("tbl%0d_addr%03h", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
    end

    // Priority with vectored mtvec
    hold_irq(4'b1100);
    step(4'b1100, 1'b1, 32'h80, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    chk("vec_trap_taken", 32'(bus.trap_taken), 32'h1);
    chk("vec_redirect_pc", bus.redirect_pc, 32'h348);
    hold_irq(4'b0000);
    rd_chk("vec_mcause", 12'h342, 32'h8000_0012);
    hold_irq(4'b1010);
    rd_chk("mip_value", 12'h344, 32'h000A_0000);
    hold_irq(4'b0000);

    // take and csr_wr in the same cycle
    wr(12'h300, 32'h8);
    hold_irq(4'b0100);
    step(4'b0100, 1'b1, 32'h60, 1'b0, 1'b1, 12'h341, 32'h99, 1'b0);
    chk("drop_trap_taken", 32'(bus.trap_taken), 32'h1);
    hold_irq(4'b0000);
    rd_chk("drop_mepc", 12'h341, 32'h60);
    wr(12'h341, 32'h123);
    rd_chk("mepc_align", 12'h341, 32'h120);

    // irq withdrawn before any valid instruction: no trap
    wr(12'h300, 32'h8);
    hold_irq(4'b0100);
    hold_irq(4'b0000);
    step(4'b0000, 1'b1, 32'h70, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
    chk("withdrawn_no_trap", 32'(bus.trap_taken), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r_irq;
      logic         r_iv, r_rd, r_wr, r_mret;
      logic [11:0]  r_addr;
      logic [31:0]  r_wd;
      r_irq  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      r_iv   = ($urandom_range(0, 3) != 0);
      r_rd   = $urandom_range(0, 1) == 1;
      r_wr   = ($urandom_range(0, 3) == 0);
      r_mret = !r_wr && ($urandom_range(0, 7) == 0);
      r_addr = addr_pool[$urandom_range(0, 7)];
      r_wd   = $urandom;
      step(r_irq, r_iv, $urandom & ~32'h3, r_rd, r_wr, r_addr, r_wd, r_mret);
    end

    // irq-to-trap latency
    hold_irq(4'b0000);
    wr(12'h304, 32'h0001_0000);
    wr(12'h300, 32'h8);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      step(4'b0001, 1'b1, 32'h200, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      if (bus.trap_taken) begin
        lat = n;
        break;
      end
    end
    chk("irq_latency", 32'(lat), SYNC ? 32'd3 : 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
